// File: rtl/clock_monitor.sv
// Measures the high/low durations of an asynchronous monitored clock in system-clock cycles,
// flags frequency/duty deviations, detects clock loss and reports lock after consecutive good periods.
module clock_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HIGH = 5,
    parameter int EXP_LOW  = 5,
    parameter int TOL      = 1,
    parameter int TIMEOUT  = 64,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_valid,
    output logic             freq_err,
    output logic             duty_err,
    output logic             clk_lost,
    output logic             locked
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]    EXP_SUM   = (CNT_W + 1)'(EXP_HIGH + EXP_LOW);
    localparam logic [CNT_W:0]    EXP_HI    = (CNT_W + 1)'(EXP_HIGH);
    localparam logic [CNT_W:0]    TOL_W     = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_W = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_W    = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t             state_q;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]   cnt_q, high_q, measHigh_q, measLow_q;
    logic [GOOD_W-1:0]  good_q;
    logic               measValid_q, freqErr_q, dutyErr_q, clkLost_q, locked_q;

    logic               rise, fall;
    logic [CNT_W:0]     periodSum, freqDev, highExt, dutyDev;
    logic               freqErr_d, dutyErr_d;
    logic [CNT_W-1:0]   cntInc_d;
    logic [GOOD_W-1:0]  goodInc_d;

    // Two-flop synchronizer plus a delay flop; both edges see the same fixed lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= mon_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Deviations use one extra bit and pick the non-negative ordering, so nothing wraps.
    always_comb begin
        periodSum = {1'b0, high_q} + {1'b0, cnt_q};
        freqDev   = (periodSum >= EXP_SUM) ? (periodSum - EXP_SUM) : (EXP_SUM - periodSum);
        highExt   = {1'b0, high_q};
        dutyDev   = (highExt >= EXP_HI) ? (highExt - EXP_HI) : (EXP_HI - highExt);
        freqErr_d = freqDev > TOL_W;
        dutyErr_d = dutyDev > TOL_W;
        cntInc_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        goodInc_d = (good_q >= LOCK_W) ? good_q : good_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_q      <= '0;
            measHigh_q  <= '0;
            measLow_q   <= '0;
            good_q      <= '0;
            measValid_q <= 1'b0;
            freqErr_q   <= 1'b0;
            dutyErr_q   <= 1'b0;
            clkLost_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            measValid_q <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                good_q    <= '0;
                locked_q  <= 1'b0;
                clkLost_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= WAIT_RISE;
                    WAIT_RISE: begin
                        if (rise) begin
                            state_q   <= MEAS_HIGH;
                            cnt_q     <= CNT_W'(1);
                            clkLost_q <= 1'b0;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            high_q  <= cnt_q;
                            cnt_q   <= CNT_W'(1);
                            state_q <= MEAS_LOW;
                        end else if (cnt_q >= TIMEOUT_W) begin
                            clkLost_q <= 1'b1;
                            locked_q  <= 1'b0;
                            good_q    <= '0;
                            cnt_q     <= '0;
                            state_q   <= WAIT_RISE;
                        end else begin
                            cnt_q <= cntInc_d;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            measHigh_q  <= high_q;
                            measLow_q   <= cnt_q;
                            measValid_q <= 1'b1;
                            freqErr_q   <= freqErr_d;
                            dutyErr_q   <= dutyErr_d;
                            if (freqErr_d || dutyErr_d) begin
                                good_q   <= '0;
                                locked_q <= 1'b0;
                            end else begin
                                good_q   <= goodInc_d;
                                locked_q <= (goodInc_d == LOCK_W);
                            end
                            cnt_q   <= CNT_W'(1);
                            state_q <= MEAS_HIGH;
                        end else if (cnt_q >= TIMEOUT_W) begin
                            clkLost_q <= 1'b1;
                            locked_q  <= 1'b0;
                            good_q    <= '0;
                            cnt_q     <= '0;
                            state_q   <= WAIT_RISE;
                        end else begin
                            cnt_q <= cntInc_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign meas_high  = measHigh_q;
    assign meas_low   = measLow_q;
    assign meas_valid = measValid_q;
    assign freq_err   = freqErr_q;
    assign duty_err   = dutyErr_q;
    assign clk_lost   = clkLost_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: clk-aligned period vectors feed a scoreboard checked on meas_valid,
// plus hand-written loss, enable, reset and asynchronous-phase sequences.
`timescale 1ns/1ps
module tb_clock_monitor;

    localparam int CNT_W    = 16;
    localparam int EXP_HIGH = 5;
    localparam int EXP_LOW  = 5;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 64;
    localparam int LOCK_CNT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             mon_clk = 1'b0;
    logic [CNT_W-1:0] meas_high, meas_low;
    logic             meas_valid, freq_err, duty_err, clk_lost, locked;

    clock_monitor #(
        .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW),
        .TOL(TOL), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mon_clk(mon_clk),
        .meas_high(meas_high), .meas_low(meas_low), .meas_valid(meas_valid),
        .freq_err(freq_err), .duty_err(duty_err), .clk_lost(clk_lost), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        bit fe;
        bit de;
        bit lk;
    } vec_t;

    vec_t sbq[$];
    vec_t expV;
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    bit   asyncMode = 1'b0;
    int   asyncValids = 0;
    int   lat;
    int   sum;
    real  phaseNs;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int hi, input int lo, input bit fe, input bit de,
                                 input bit lk, input bit push);
        if (push) sbq.push_back('{hi, lo, fe, de, lk});
        mon_clk = 1'b1;
        tick(hi);
        mon_clk = 1'b0;
        tick(lo);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_meas_high"}, meas_high, 0);
        checkOutput({tag, "_meas_low"}, meas_low, 0);
        checkOutput({tag, "_meas_valid"}, meas_valid, 0);
        checkOutput({tag, "_freq_err"}, freq_err, 0);
        checkOutput({tag, "_duty_err"}, duty_err, 0);
        checkOutput({tag, "_clk_lost"}, clk_lost, 0);
        checkOutput({tag, "_locked"}, locked, 0);
    endtask

    // Every meas_valid pops one expected period, or in async mode is range-checked.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (asyncMode) begin
                asyncValids++;
                sum = int'(meas_high) + int'(meas_low);
                checks++;
                if (sum < 10 || sum > 11) begin
                    errors++;
                    $display("[TB] FAIL async_period: got %0d, expected 10..11", sum);
                end
                checkOutput("async_freq_err", freq_err, 0);
                checkOutput("async_duty_err", duty_err, 0);
                if (asyncValids >= LOCK_CNT) checkOutput("async_locked", locked, 1);
            end else if (sbq.size() == 0) begin
                checkOutput("unexpected_meas_valid", 1, 0);
            end else begin
                expV = sbq.pop_front();
                checkOutput("meas_high", meas_high, expV.hi);
                checkOutput("meas_low", meas_low, expV.lo);
                checkOutput("freq_err", freq_err, expV.fe);
                checkOutput("duty_err", duty_err, expV.de);
                checkOutput("locked", locked, expV.lk);
                checkOutput("clk_lost_on_valid", clk_lost, 0);
            end
        end
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs = '{
            '{5, 5, 0, 0, 0}, '{5, 5, 0, 0, 0}, '{5, 5, 0, 0, 0}, '{5, 5, 0, 0, 1},
            '{5, 5, 0, 0, 1}, '{7, 3, 0, 1, 0}, '{5, 5, 0, 0, 0}, '{5, 5, 0, 0, 0},
            '{5, 5, 0, 0, 0}, '{5, 5, 0, 0, 1}, '{6, 5, 0, 0, 1}, '{6, 6, 1, 0, 0},
            '{4, 4, 1, 0, 0}, '{5, 5, 0, 0, 0}
        };

        tick(2);
        rst = 1'b0;
        checkResetOutputs("reset");
        enable = 1'b1;
        tick(4);

        // Nominal lock, duty error, tolerance edge and frequency errors.
        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i].hi, vecs[i].lo, vecs[i].fe, vecs[i].de, vecs[i].lk, 1'b1);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);
        applyStimulus(5, 5, 0, 0, 1, 1'b1);

        // Clock loss: one high phase, then mon_clk held low.
        mon_clk = 1'b1;
        tick(5);
        mon_clk = 1'b0;
        lat = 0;
        while (!clk_lost && lat < 100) begin
            tick(1);
            lat++;
        end
        checkOutput("lost_latency", lat, 3 + TIMEOUT);
        checkOutput("lost_locked", locked, 0);
        checkOutput("lost_meas_high_held", meas_high, 5);
        checkOutput("lost_meas_low_held", meas_low, 5);
        checkOutput("lost_drain", sbq.size(), 0);
        tick(10);
        checkOutput("lost_sticky", clk_lost, 1);

        mon_clk = 1'b1;
        sbq.push_back('{5, 5, 0, 0, 0});
        tick(2);
        checkOutput("lost_before_rise", clk_lost, 1);
        tick(1);
        checkOutput("lost_cleared", clk_lost, 0);
        tick(2);
        mon_clk = 1'b0;
        tick(5);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);
        applyStimulus(5, 5, 0, 0, 1, 1'b1);

        // Enable drop during MEAS_HIGH, then re-enable inside a long partial high phase.
        mon_clk = 1'b1;
        tick(4);
        enable = 1'b0;
        tick(1);
        checkOutput("dis_locked", locked, 0);
        checkOutput("dis_clk_lost", clk_lost, 0);
        checkOutput("dis_meas_high_held", meas_high, 5);
        checkOutput("dis_meas_low_held", meas_low, 5);
        tick(1);
        mon_clk = 1'b0;
        tick(5);
        applyStimulus(5, 5, 0, 0, 0, 1'b0);
        applyStimulus(5, 5, 0, 0, 0, 1'b0);
        mon_clk = 1'b1;
        tick(3);
        enable = 1'b1;
        tick(4);
        mon_clk = 1'b0;
        tick(5);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);
        applyStimulus(5, 5, 0, 0, 0, 1'b1);

        // Reset while in MEAS_LOW.
        mon_clk = 1'b1;
        tick(5);
        mon_clk = 1'b0;
        tick(4);
        checkOutput("pre_reset_drain", sbq.size(), 0);
        rst = 1'b1;
        tick(1);
        checkResetOutputs("midreset");
        rst = 1'b0;
        sbq.delete();

        // Asynchronous 10.3-cycle clock with a phase that never lands on a clk edge.
        asyncMode = 1'b1;
        phaseNs = $urandom_range(0, 19) * 0.5 + 0.137;
        #(phaseNs);
        repeat (200) begin
            mon_clk = 1'b1;
            #51.5;
            mon_clk = 1'b0;
            #51.5;
        end
        tick(3);
        asyncMode = 1'b0;
        checkOutput("async_valid_count_ok", (asyncValids >= 195) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
